bitwise_arbiter: RTL



---
 rtl/bitwise_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bitwise_arbiter.sv
// ---------------------------------------------------------------------------
// bitwise_arbiter
//
// Shares one registered bitwise logic unit (AND / OR / XOR / NOR) between two
// requesters. Round-robin arbitration picks one requester per cycle. The
// chosen operation is computed and captured in a single-entry result register
// that carries the requester ID. With the consumer always ready, the block
// accepts one operation per cycle, and each result appears one cycle after
// its request is accepted.
//
// Ports
//   clock                  rising-edge clock
//   reset_n                asynchronous, active-low reset
//   req0_valid / req0_ready  handshake, requester 0
//   req0_op                00 AND, 01 OR, 10 XOR, 11 NOR
//   req0_a / req0_b        operands, requester 0
//   req1_*                 same set of signals for requester 1
//   res_valid / res_ready  handshake on the result port
//   res_id                 requester that issued the held result
//   res_data               held result
// ---------------------------------------------------------------------------
module bitwise_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_data
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       last_grant;
    logic       grant;
    logic       can_accept;
    logic       accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] op_result;

    function automatic logic [WIDTH-1:0] bitop(input logic [1:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    assign res_valid = (state_q == FULL);

    // Arbitration and handshake. The slot is free when it is empty or when
    // it drains this cycle, so res_ready reaches the request readies
    // combinationally. It never reaches res_data.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // can leave it unassigned and infer a latch.
        grant      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        can_accept = ~res_valid | res_ready;

        // Under contention the requester that did not win last time goes
        // first. A lone requester wins outright.
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;

        req0_ready = can_accept & req0_valid & ~grant;
        req1_ready = can_accept & req1_valid &  grant;
    end

    assign accept    = req0_ready | req1_ready;
    assign sel_op    = grant ? req1_op : req0_op;
    assign sel_a     = grant ? req1_a  : req0_a;
    assign sel_b     = grant ? req1_b  : req0_b;
    assign op_result = bitop(sel_op, sel_a, sel_b);

    // Next-state logic for the result slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (accept)         state_d = FULL;
                     else if (res_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // The result register and grant history. When the slot drains with no
    // new accept, res_id/res_data keep their stale contents. Only res_valid
    // falls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: last_grant resets to 1 so requester 0 wins the first
            // contention. The datapath register is also cleared because its
            // contents are visible on res_data.
            last_grant <= 1'b1;
            res_id     <= 1'b0;
            res_data   <= '0;
        end else if (accept) begin
            last_grant <= grant;
            res_id     <= grant;
            res_data   <= op_result;
        end
    end

endmodule
